// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and register scoreboard in front of the 32x32 register file.
// NREQ requesters share one write port under round-robin arbitration. A single
// registered output stage drives the register file. A busy bit per register
// lets decode stall on writes that are still pending.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_rd,
  input  logic [DW*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 iss_valid,
  input  logic [4:0]           iss_rd,
  input  logic [4:0]           chk_rs1,
  input  logic [4:0]           chk_rs2,
  output logic                 busy_rs1,
  output logic                 busy_rs2,
  output logic                 RegWre,
  output logic                 wren,
  output logic [4:0]           WriteReg,
  output logic [DW-1:0]        WriteData,
  output logic                 idle,
  output logic                 err_wb
);

  logic [2:0]    rr_ptr_q, rr_ptr_d;
  logic          regwre_q, regwre_d;
  logic [4:0]    wreg_q, wreg_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [31:0]   busy_q, busy_d;
  logic          err_q, err_d;

  logic          gnt_vld;
  logic [2:0]    gnt_idx;
  logic [4:0]    sel_rd;
  logic [DW-1:0] sel_data;
  logic          hit_hi, hit_lo;
  logic [2:0]    idx_hi, idx_lo;
  logic          set_hit;

  // Round-robin pick: first valid at or above rr_ptr, otherwise first valid overall (wrap).
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = 3'd0;
    idx_lo = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !hit_lo) begin
        hit_lo = 1'b1;
        idx_lo = 3'(i);
      end
      if (req_valid[i] && !hit_hi && (3'(i) >= rr_ptr_q)) begin
        hit_hi = 1'b1;
        idx_hi = 3'(i);
      end
    end
    gnt_vld = hit_lo;
    gnt_idx = hit_hi ? idx_hi : idx_lo;
  end

  // One-hot grant and mux of the granted requester's destination and data.
  always_comb begin
    req_ready = '0;
    sel_rd    = 5'd0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_vld && (gnt_idx == 3'(i))) begin
        req_ready[i] = 1'b1;
        sel_rd       = req_rd[5*i +: 5];
        sel_data     = req_data[DW*i +: DW];
      end
    end
  end

  // Next state of pointer and output stage; a grant to x0 is consumed but never written.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    regwre_d = 1'b0;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    if (gnt_vld) begin
      rr_ptr_d = (gnt_idx == 3'(NREQ-1)) ? 3'd0 : gnt_idx + 3'd1;
      regwre_d = (sel_rd != 5'd0);
      wreg_d   = sel_rd;
      wdata_d  = sel_data;
    end
  end

  // Scoreboard: clear on commit, set on issue (set wins), flag commits to idle registers.
  always_comb begin
    busy_d  = busy_q;
    err_d   = err_q;
    set_hit = iss_valid && (iss_rd != 5'd0);
    if (regwre_q) begin
      if (!busy_q[wreg_q] && !(set_hit && (iss_rd == wreg_q)))
        err_d = 1'b1;
      busy_d[wreg_q] = 1'b0;
    end
    if (set_hit)
      busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr_q <= 3'd0;
      regwre_q <= 1'b0;
      wreg_q   <= 5'd0;
      wdata_q  <= '0;
      busy_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      regwre_q <= regwre_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign RegWre    = regwre_q;
  assign wren      = regwre_q;
  assign WriteReg  = wreg_q;
  assign WriteData = wdata_q;
  assign err_wb    = err_q;
  assign busy_rs1  = (chk_rs1 != 5'd0) && busy_q[chk_rs1];
  assign busy_rs2  = (chk_rs2 != 5'd0) && busy_q[chk_rs2];
  assign idle      = ~(|busy_q[31:1]) & ~regwre_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios with literal expectations, then
// randomized traffic, all continuously compared against a behavioural model.
module tb_rf_wb_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 32;

  logic                CLK = 1'b0;
  logic                RST;
  logic [NREQ-1:0]     req_valid;
  logic [5*NREQ-1:0]   req_rd;
  logic [DW*NREQ-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                iss_valid;
  logic [4:0]          iss_rd, chk_rs1, chk_rs2;
  logic                busy_rs1, busy_rs2, RegWre, wren, idle, err_wb;
  logic [4:0]          WriteReg;
  logic [DW-1:0]       WriteData;

  rf_wb_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .iss_valid(iss_valid), .iss_rd(iss_rd), .chk_rs1(chk_rs1),
    .chk_rs2(chk_rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .RegWre(RegWre),
    .wren(wren), .WriteReg(WriteReg), .WriteData(WriteData), .idle(idle), .err_wb(err_wb)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  int          m_ptr;
  bit [31:0]   m_busy;
  bit          m_we, m_err;
  int          m_wr;
  logic [DW-1:0] m_wd;
  int          m_last_g;
  logic [DW-1:0] m_rf [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  // Model update at each active edge
  always @(posedge CLK) begin
    if (RST) begin
      m_ptr = 0; m_busy = '0; m_we = 0; m_wr = 0; m_wd = '0; m_err = 0; m_last_g = -1;
    end else begin
      int g;
      bit setting;
      g = model_grant();
      m_last_g = g;
      setting = iss_valid && (iss_rd != 0);
      if (m_we) begin
        m_rf[m_wr] = m_wd;
        if (!m_busy[m_wr] && !(setting && int'(iss_rd) == m_wr)) m_err = 1;
        m_busy[m_wr] = 0;
      end
      if (setting) m_busy[iss_rd] = 1;
      if (g >= 0) begin
        m_wr  = int'(req_rd[5*g +: 5]);
        m_wd  = req_data[DW*g +: DW];
        m_we  = (m_wr != 0);
        m_ptr = (g + 1) % NREQ;
      end else begin
        m_we = 0;
      end
    end
    cmp_en = 1'b1;
  end

  // Compare DUT against model every cycle, away from the active edge
  always @(negedge CLK) begin
    if (cmp_en) begin
      int g;
      logic [NREQ-1:0] exp_rdy;
      #2;
      g = model_grant();
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("m_req_ready", req_ready, exp_rdy);
      chk("m_RegWre", RegWre, m_we);
      chk("m_wren", wren, m_we);
      chk("m_WriteReg", WriteReg, m_wr[4:0]);
      chk("m_WriteData", WriteData, m_wd);
      chk("m_busy_rs1", busy_rs1, (chk_rs1 != 0) && m_busy[chk_rs1]);
      chk("m_busy_rs2", busy_rs2, (chk_rs2 != 0) && m_busy[chk_rs2]);
      chk("m_idle", idle, (m_busy[31:1] == 0) && !m_we);
      chk("m_err_wb", err_wb, m_err);
    end
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet();
    req_valid = '0; req_rd = '0; req_data = '0;
    iss_valid = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
  endtask

  task automatic do_reset();
    quiet();
    RST = 1;
    tick();
    RST = 0;
  endtask

  logic [NREQ-1:0] pend;

  initial begin
    logic [NREQ-1:0] exp_g [4];
    int exp_wr [4];
    RST = 1;
    quiet();
    @(negedge CLK);

    // 1: reset dominates valid requests and issues
    req_valid = '1; req_rd = {5'd7, 5'd6, 5'd5}; iss_valid = 1; iss_rd = 5'd3; chk_rs1 = 5'd3;
    tick();
    settle();
    chk("rst_RegWre", RegWre, 1'b0);
    chk("rst_ready", req_ready, 3'b001);
    chk("rst_busy", busy_rs1, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_err", err_wb, 1'b0);
    tick();
    RST = 0;

    // 2: round robin with all three held valid
    do_reset();
    req_valid = 3'b111; req_rd = {5'd7, 5'd6, 5'd5};
    req_data = {32'h102, 32'h101, 32'h100};
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_wr = '{5, 6, 7, 5};
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("rr_ready", req_ready, exp_g[k]);
      tick();
      settle();
      chk("rr_wreg", WriteReg, exp_wr[k]);
      chk("rr_we", RegWre, 1'b1);
    end
    // 2b: each requester drops valid after its grant
    do_reset();
    req_valid = 3'b111;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("rrd_ready", req_ready, exp_g[k]);
      tick();
      req_valid[k] = 1'b0;
    end
    settle();
    chk("rrd_empty", req_ready, 3'b000);

    // 3: scoreboard timing for x9
    do_reset();
    chk_rs1 = 5'd9; iss_valid = 1; iss_rd = 5'd9;
    tick();
    iss_valid = 0;
    settle();
    chk("sb_busy_p0", busy_rs1, 1'b1);
    tick();
    tick();
    req_valid = 3'b001; req_rd[4:0] = 5'd9; req_data[31:0] = 32'hDEADBEEF;
    settle();
    chk("sb_ready", req_ready, 3'b001);
    chk("sb_busy_p2", busy_rs1, 1'b1);
    tick();
    req_valid = 3'b000;
    settle();
    chk("sb_we_p3", RegWre, 1'b1);
    chk("sb_wd_p3", WriteData, 32'hDEADBEEF);
    chk("sb_busy_p3", busy_rs1, 1'b1);
    tick();
    settle();
    chk("sb_we_p4", RegWre, 1'b0);
    chk("sb_busy_p4", busy_rs1, 1'b0);
    chk("sb_rf_x9", m_rf[9], 32'hDEADBEEF);
    chk("sb_err", err_wb, 1'b0);

    // 4: x0 is never busy and never written
    do_reset();
    iss_valid = 1; iss_rd = 5'd0;
    tick();
    iss_valid = 0; req_valid = 3'b001; req_rd[4:0] = 5'd0; req_data[31:0] = 32'h1;
    settle();
    chk("x0_idle", idle, 1'b1);
    chk("x0_ready", req_ready, 3'b001);
    tick();
    req_valid = 3'b011; req_rd[4:0] = 5'd3; req_rd[9:5] = 5'd3;
    settle();
    chk("x0_we", RegWre, 1'b0);
    chk("x0_ptr", req_ready, 3'b010);
    tick();
    req_valid = 3'b001;
    tick();
    req_valid = 3'b000;

    // 5: set and clear of x4 on the same edge
    do_reset();
    chk_rs1 = 5'd4; iss_valid = 1; iss_rd = 5'd4;
    tick();
    iss_valid = 0; req_valid = 3'b001; req_rd[4:0] = 5'd4; req_data[31:0] = 32'h44;
    tick();
    req_valid = 3'b000; iss_valid = 1; iss_rd = 5'd4;
    settle();
    chk("col_we", RegWre, 1'b1);
    chk("col_wreg", WriteReg, 5'd4);
    tick();
    iss_valid = 0;
    settle();
    chk("col_busy", busy_rs1, 1'b1);
    chk("col_err", err_wb, 1'b0);

    // 6: commit to idle register, then reset mid-operation
    do_reset();
    req_valid = 3'b001; req_rd[4:0] = 5'd12; req_data[31:0] = 32'h55;
    tick();
    req_valid = 3'b000;
    settle();
    chk("err_we", RegWre, 1'b1);
    chk("err_wreg", WriteReg, 5'd12);
    tick();
    settle();
    chk("err_set", err_wb, 1'b1);
    chk("err_land", m_rf[12], 32'h55);
    chk_rs1 = 5'd13; iss_valid = 1; iss_rd = 5'd13;
    req_valid = 3'b010; req_rd[9:5] = 5'd14; req_data[63:32] = 32'h66;
    tick();
    iss_valid = 0; req_valid = 3'b000;
    settle();
    chk("mid_busy", busy_rs1, 1'b1);
    chk("mid_we", RegWre, 1'b1);
    RST = 1;
    tick();
    RST = 0; req_valid = 3'b011;
    settle();
    chk("mid_we0", RegWre, 1'b0);
    chk("mid_err0", err_wb, 1'b0);
    chk("mid_idle", idle, 1'b1);
    chk("mid_busy0", busy_rs1, 1'b0);
    chk("mid_ready", req_ready, 3'b001);
    tick();
    req_valid = 3'b010;
    tick();
    req_valid = 3'b000;

    // Randomized traffic: requesters hold until accepted
    do_reset();
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] && !RST && m_last_g == i) pend[i] = 1'b0;
        if (!pend[i] && ($urandom % 3 == 0)) begin
          pend[i] = 1'b1;
          req_rd[5*i +: 5]    = 5'($urandom_range(0, 31));
          req_data[DW*i +: DW] = $urandom;
        end
      end
      req_valid = pend;
      RST       = ($urandom % 100 == 0);
      iss_valid = ($urandom % 3 == 0);
      iss_rd    = 5'($urandom_range(0, 31));
      chk_rs1   = 5'($urandom_range(0, 31));
      chk_rs2   = 5'($urandom_range(0, 31));
      tick();
    end
    RST = 0;
    quiet();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
